sid_bus_arb: RTL and testbench
==============================

SID_BUS_ARB -- requirements
Module: sid_bus_arb

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning internal-write FIFO entries (power of two, 2..16).
REQ-002 SHALL have port clk  input  1  system clock (24 MHz domain).
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port phi2  input  1  SID master clock, already synchronised to clk.
REQ-005 SHALL have port ext_we  input  1  external bus write strobe, one clk pulse per write.
REQ-006 SHALL have port ext_addr  input  5  external write register address.
REQ-007 SHALL have port ext_data  input  8  external write data.
REQ-008 SHALL have port int_valid  input  1  internal requester (USB player) write valid.
REQ-009 SHALL have port int_ready  output  1  internal FIFO can accept.
REQ-010 SHALL have port int_addr  input  5  internal write register address.
REQ-011 SHALL have port int_data  input  8  internal write data.
REQ-012 SHALL have port out_we  output  1  write strobe to SID register file, one clk pulse.
REQ-013 SHALL have port out_addr  output  5  issued register address.
REQ-014 SHALL have port out_data  output  8  issued write data.
REQ-015 SHALL have port level  output  $clog2(DEPTH)+1  internal FIFO occupancy.
REQ-016 SHALL have port coll  output  1  sticky external write collision flag.
REQ-017 SHALL have port coll_clr  input  1  clears coll.

Function
REQ-018 Slot: SHALL register phi2 as phi2_q; fall = phi2_q & ~phi2; each fall is exactly one write slot; at most one out_we per slot.
REQ-019 External capture: ext_we SHALL latch ext_addr/ext_data into pending register and set ext_pend on the following clk.
REQ-020 Collision: ext_we while ext_pend already set SHALL overwrite pending with new values and set coll; coll stays 1 until coll_clr or reset.
REQ-021 coll_clr coincident with a new collision: set wins (coll = 1).
REQ-022 FIFO push: int_valid & int_ready SHALL store {int_addr,int_data}; int_ready = (level < DEPTH) and not in reset.
REQ-023 Arbitration on fall, using state registered before that clk: ext_pend = 1 -> issue pending, clear ext_pend; else level > 0 -> issue FIFO head, pop; else no write.
REQ-024 External priority is strict; internal writes only use slots with no pending external write.
REQ-025 Latency: out_we, out_addr, out_data SHALL be registered, asserted the clk after fall is detected, out_we high exactly one clk.
REQ-026 out_addr/out_data SHALL hold last issued values when out_we = 0.
REQ-027 ext_we in the same clk as fall: not issued in that slot; captured as pending for next slot (if ext_pend was also set, the older value issues now and the new one becomes pending, no collision).
REQ-028 Push into empty FIFO in the fall clk: not issued in that slot.
REQ-029 Simultaneous push and pop: level unchanged; pointers wrap modulo DEPTH.
REQ-030 int_valid while full: no push, no data loss, requester holds (level = DEPTH, int_ready = 0).
REQ-031 level SHALL update the clk after push/pop.

Reset
REQ-032 While rst_n = 0 on a clk edge: out_we 0, out_addr 0, out_data 0, level 0, int_ready 0, coll 0, ext_pend 0, phi2_q 0, FIFO pointers 0.
REQ-033 Reset mid-slot SHALL discard pending and FIFO contents; no out_we for at least one clk after rst_n rises; phi2 high at release SHALL NOT create a spurious fall.
REQ-034 int_ready SHALL be 1 the first clk after rst_n = 1.

Verification
REQ-035 Single external: ext_we addr 0x18 data 0x0F, then phi2 1->0 -> one out_we, out_addr 0x18, out_data 0x0F, 1 clk after fall.
REQ-036 Internal stream: push 4 writes (0x00/0x11..0x03/0x44), DEPTH 4 -> int_ready 0 after 4th, level 4; next 4 falls issue them in order, level 3,2,1,0.
REQ-037 Priority: FIFO holds 0x04/0x41, ext_we 0x05/0x09 before fall -> fall 1 issues 0x05/0x09, fall 2 issues 0x04/0x41.
REQ-038 Collision: two ext_we (0x01/0xAA then 0x01/0xBB) in one phi2 cycle -> one out_we with 0xBB, coll 1 until coll_clr pulse.
REQ-039 Boundary: ext_we in fall clk with empty FIFO -> no write this slot, issued at next fall.
REQ-040 Reset mid-operation: FIFO level 3, ext_pend 1, rst_n low 1 clk -> all outputs reset values, no out_we on subsequent falls until new writes.

Source files
------------

// File: rtl/sid_bus_arb.sv
// SID register-write arbiter: one write per phi2 falling edge, external bus writes take
// strict priority over a small FIFO fed by the internal (USB player) requester.
module sid_bus_arb #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       phi2,
  input  logic                       ext_we,
  input  logic [4:0]                 ext_addr,
  input  logic [7:0]                 ext_data,
  input  logic                       int_valid,
  output logic                       int_ready,
  input  logic [4:0]                 int_addr,
  input  logic [7:0]                 int_data,
  output logic                       out_we,
  output logic [4:0]                 out_addr,
  output logic [7:0]                 out_data,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       coll,
  input  logic                       coll_clr
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LW = $clog2(DEPTH) + 1;

  logic          phi2_q;
  logic          fall;

  logic          ext_pend_q, ext_pend_d;
  logic [4:0]    ext_addr_q, ext_addr_d;
  logic [7:0]    ext_data_q, ext_data_d;
  logic          coll_q, coll_d;
  logic          collide;

  logic [12:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          ready_q, ready_d;
  logic          push, pop, issue_ext;
  logic [12:0]   head;

  logic          out_we_q, out_we_d;
  logic [4:0]    out_addr_q, out_addr_d;
  logic [7:0]    out_data_q, out_data_d;

  // Arbitration looks only at state registered before this clk, so a write captured or
  // pushed in the fall clk itself waits for the next slot.
  always_comb begin
    fall      = phi2_q & ~phi2;
    issue_ext = fall & ext_pend_q;
    pop       = fall & ~ext_pend_q & (level_q != '0);
    push      = int_valid & ready_q;
    head      = mem_q[rd_ptr_q];
    // A pending value consumed in this very slot frees the register, so no collision.
    collide   = ext_we & ext_pend_q & ~fall;
  end

  always_comb begin
    ext_pend_d = ext_pend_q;
    ext_addr_d = ext_addr_q;
    ext_data_d = ext_data_q;
    coll_d     = coll_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    ready_d    = ready_q;
    out_we_d   = 1'b0;
    out_addr_d = out_addr_q;
    out_data_d = out_data_q;

    if (issue_ext) begin
      out_we_d   = 1'b1;
      out_addr_d = ext_addr_q;
      out_data_d = ext_data_q;
      ext_pend_d = 1'b0;
    end else if (pop) begin
      out_we_d   = 1'b1;
      out_addr_d = head[12:8];
      out_data_d = head[7:0];
      rd_ptr_d   = rd_ptr_q + AW'(1);
    end

    if (ext_we) begin
      ext_pend_d = 1'b1;
      ext_addr_d = ext_addr;
      ext_data_d = ext_data;
    end

    if (collide) begin
      coll_d = 1'b1;
    end else if (coll_clr) begin
      coll_d = 1'b0;
    end

    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    level_d = level_q + LW'(push) - LW'(pop);
    ready_d = (level_d < LW'(DEPTH));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phi2_q     <= 1'b0;
      ext_pend_q <= 1'b0;
      ext_addr_q <= '0;
      ext_data_q <= '0;
      coll_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      ready_q    <= 1'b0;
      out_we_q   <= 1'b0;
      out_addr_q <= '0;
      out_data_q <= '0;
    end else begin
      phi2_q     <= phi2;
      ext_pend_q <= ext_pend_d;
      ext_addr_q <= ext_addr_d;
      ext_data_q <= ext_data_d;
      coll_q     <= coll_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      ready_q    <= ready_d;
      out_we_q   <= out_we_d;
      out_addr_q <= out_addr_d;
      out_data_q <= out_data_d;
    end
  end

  // Storage needs no reset: pointers and level define which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {int_addr, int_data};
    end
  end

  assign int_ready = ready_q;
  assign out_we    = out_we_q;
  assign out_addr  = out_addr_q;
  assign out_data  = out_data_q;
  assign level     = level_q;
  assign coll      = coll_q;

endmodule

// File: tb/tb_sid_bus_arb.sv
// Bench for sid_bus_arb: directed scenarios plus random traffic, all checked cycle by
// cycle against a queue-based model of the slot/priority rules.
module tb_sid_bus_arb;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned LW = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n, phi2, ext_we, int_valid, coll_clr;
  logic [4:0]    ext_addr, int_addr;
  logic [7:0]    ext_data, int_data;
  logic          int_ready, out_we, coll;
  logic [4:0]    out_addr;
  logic [7:0]    out_data;
  logic [LW-1:0] level;

  int n_checks = 0;
  int n_fail   = 0;

  sid_bus_arb #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .phi2      (phi2),
    .ext_we    (ext_we),
    .ext_addr  (ext_addr),
    .ext_data  (ext_data),
    .int_valid (int_valid),
    .int_ready (int_ready),
    .int_addr  (int_addr),
    .int_data  (int_data),
    .out_we    (out_we),
    .out_addr  (out_addr),
    .out_data  (out_data),
    .level     (level),
    .coll      (coll),
    .coll_clr  (coll_clr)
  );

  always #5 clk = ~clk;

  // Reference model state.
  logic [12:0] m_fifo[$];
  logic        m_phi2_prev = 1'b0;
  logic        m_pend = 1'b0;
  logic [12:0] m_pend_val = '0;
  logic        m_coll = 1'b0;
  logic        m_ready = 1'b0;
  logic        m_we = 1'b0;
  logic [4:0]  m_addr = '0;
  logic [7:0]  m_data = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step_model();
    logic [12:0] v;
    logic        fall;
    if (!rst_n) begin
      m_fifo.delete();
      m_phi2_prev = 1'b0;
      m_pend = 1'b0;
      m_pend_val = '0;
      m_coll = 1'b0;
      m_ready = 1'b0;
      m_we = 1'b0;
      m_addr = '0;
      m_data = '0;
    end else begin
      fall = m_phi2_prev && !phi2;
      m_we = 1'b0;
      if (fall) begin
        if (m_pend) begin
          m_we = 1'b1;
          {m_addr, m_data} = m_pend_val;
          m_pend = 1'b0;
        end else if (m_fifo.size() > 0) begin
          v = m_fifo.pop_front();
          m_we = 1'b1;
          {m_addr, m_data} = v;
        end
      end
      if (int_valid && m_ready) m_fifo.push_back({int_addr, int_data});
      if (ext_we && m_pend) m_coll = 1'b1;
      else if (coll_clr) m_coll = 1'b0;
      if (ext_we) begin
        m_pend = 1'b1;
        m_pend_val = {ext_addr, ext_data};
      end
      m_phi2_prev = phi2;
      m_ready = (m_fifo.size() < DEPTH);
    end
  endtask

  // One clk: drive on the falling edge, update model at the rising edge, compare 1 later.
  task automatic cyc(input logic p, input logic we, input logic [4:0] ea, input logic [7:0] ed,
                     input logic iv, input logic [4:0] ia, input logic [7:0] id,
                     input logic clr, input logic rn);
    @(negedge clk);
    phi2 = p; ext_we = we; ext_addr = ea; ext_data = ed;
    int_valid = iv; int_addr = ia; int_data = id; coll_clr = clr; rst_n = rn;
    @(posedge clk);
    step_model();
    #1;
    check("out_we", 32'(out_we), 32'(m_we));
    check("out_addr", 32'(out_addr), 32'(m_addr));
    check("out_data", 32'(out_data), 32'(m_data));
    check("level", 32'(level), 32'(m_fifo.size()));
    check("int_ready", 32'(int_ready), 32'(m_ready));
    check("coll", 32'(coll), 32'(m_coll));
  endtask

  task automatic idle(input logic p);
    cyc(p, 1'b0, 5'h0, 8'h0, 1'b0, 5'h0, 8'h0, 1'b0, 1'b1);
  endtask

  task automatic slot();
    idle(1'b1);
    idle(1'b0);
  endtask

  initial begin
    logic rp;
    rst_n = 1'b0; phi2 = 1'b0; ext_we = 1'b0; ext_addr = '0; ext_data = '0;
    int_valid = 1'b0; int_addr = '0; int_data = '0; coll_clr = 1'b0;

    // Reset with phi2 high, then release with phi2 still high: no spurious fall.
    repeat (3) cyc(1'b1, 1'b0, 5'h0, 8'h0, 1'b0, 5'h0, 8'h0, 1'b0, 1'b0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_ready", 32'(int_ready), 32'd0);
    idle(1'b1);
    check("ready_after_rst", 32'(int_ready), 32'd1);
    idle(1'b1);

    // Single external write.
    cyc(1'b1, 1'b1, 5'h18, 8'h0F, 1'b0, 5'h0, 8'h0, 1'b0, 1'b1);
    idle(1'b1);
    idle(1'b0);
    check("ext_we", 32'(out_we), 32'd1);
    check("ext_addr", 32'(out_addr), 32'h18);
    check("ext_data", 32'(out_data), 32'h0F);
    idle(1'b0);
    check("ext_once", 32'(out_we), 32'd0);
    check("ext_hold", 32'(out_data), 32'h0F);

    // Internal stream fills the FIFO, then drains one per slot.
    for (int i = 0; i < 4; i++)
      cyc(1'b0, 1'b0, 5'h0, 8'h0, 1'b1, 5'(i), 8'((i + 1) * 8'h11), 1'b0, 1'b1);
    check("full_level", 32'(level), 32'd4);
    check("full_ready", 32'(int_ready), 32'd0);
    cyc(1'b0, 1'b0, 5'h0, 8'h0, 1'b1, 5'h1F, 8'hEE, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      slot();
      check("drain_data", 32'(out_data), 32'((i + 1) * 8'h11));
    end

    // Strict priority of a pending external write over the FIFO head.
    cyc(1'b0, 1'b0, 5'h0, 8'h0, 1'b1, 5'h04, 8'h41, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 5'h05, 8'h09, 1'b0, 5'h0, 8'h0, 1'b0, 1'b1);
    idle(1'b0);
    check("prio_first", 32'(out_addr), 32'h05);
    slot();
    check("prio_second", 32'(out_addr), 32'h04);

    // Collision: second write overwrites, sticky flag until cleared.
    cyc(1'b1, 1'b1, 5'h01, 8'hAA, 1'b0, 5'h0, 8'h0, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 5'h01, 8'hBB, 1'b0, 5'h0, 8'h0, 1'b0, 1'b1);
    idle(1'b0);
    check("coll_data", 32'(out_data), 32'hBB);
    check("coll_set", 32'(coll), 32'd1);
    slot();
    check("coll_one_write", 32'(out_we), 32'd0);
    cyc(1'b0, 1'b0, 5'h0, 8'h0, 1'b0, 5'h0, 8'h0, 1'b1, 1'b1);
    check("coll_clr", 32'(coll), 32'd0);

    // External write in the fall clk itself waits one slot.
    idle(1'b1);
    cyc(1'b0, 1'b1, 5'h0A, 8'h55, 1'b0, 5'h0, 8'h0, 1'b0, 1'b1);
    check("late_ext_none", 32'(out_we), 32'd0);
    slot();
    check("late_ext_next", 32'(out_data), 32'h55);

    // Reset mid-operation discards pending and FIFO contents.
    for (int i = 0; i < 3; i++)
      cyc(1'b0, 1'b0, 5'h0, 8'h0, 1'b1, 5'(i + 8), 8'(i + 8'h70), 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 5'h07, 8'h77, 1'b0, 5'h0, 8'h0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 5'h0, 8'h0, 1'b0, 5'h0, 8'h0, 1'b0, 1'b0);
    check("midrst_level", 32'(level), 32'd0);
    for (int i = 0; i < 4; i++) slot();

    // Random traffic.
    rp = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(2) == 0) rp = ~rp;
      cyc(rp, ($urandom_range(7) == 0), 5'($urandom), 8'($urandom),
          1'($urandom), 5'($urandom), 8'($urandom),
          ($urandom_range(15) == 0), ($urandom_range(299) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
